// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad debouncer: FSM state encoding and
// one-hot to binary index conversion.
package keypad_pkg;

   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

   localparam int MAX_KEYS = 256;

   function automatic int onehot_to_index(input logic [MAX_KEYS-1:0] v);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_KEYS; i++)
         if (v[i]) idx = i;
      return idx;
   endfunction

endpackage

// File: rtl/debounce_counter.sv
// Loadable, clearable up-counter with a terminal-match flag against a
// runtime-selectable terminal value.
module debounce_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         load,
   input  logic         inc,
   input  logic [W-1:0] load_val,
   input  logic [W-1:0] term,
   output logic [W-1:0] count,
   output logic         match
);

   always_ff @(posedge clk) begin
      if (reset || clear) count <= '0;
      else if (load)      count <= load_val;
      else if (inc)       count <= count + 1'b1;
   end

   assign match = (count == term);

endmodule

// File: rtl/keypad_debouncer.sv
// Debounces a synchronised one-hot key vector, locks onto a single key and
// emits press / release pulses with optional typematic repeat.
module keypad_debouncer
   import keypad_pkg::*;
#(
   parameter int NUM_KEYS       = 16,
   parameter int PRESS_CYCLES   = 4,
   parameter int RELEASE_CYCLES = 4,
   parameter int REPEAT_EN      = 0,
   parameter int REPEAT_DELAY   = 8,
   parameter int REPEAT_RATE    = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_KEYS-1:0]         keys_pressed,
   output logic [NUM_KEYS-1:0]         key_pressed_value,
   output logic [$clog2(NUM_KEYS)-1:0] key_index,
   output logic                        new_key,
   output logic                        key_released,
   output logic                        key_held
);

   localparam int IW   = $clog2(NUM_KEYS);
   localparam int CMAX = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int RW   = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

   localparam logic [CW-1:0] PRESS_T  = CW'(PRESS_CYCLES - 1);
   localparam logic [CW-1:0] REL_T    = CW'(RELEASE_CYCLES - 1);
   localparam logic [RW-1:0] RPT_FST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RPT_WRAP = RW'(REPEAT_DELAY + REPEAT_RATE - 1);
   localparam logic [RW-1:0] RPT_LD   = RW'(REPEAT_DELAY);

   state_t              state;
   logic [NUM_KEYS-1:0] cand;

   logic          onehot, qual, locked_hi, rpt_fire;
   logic          cnt_clr, cnt_ld, cnt_inc, cnt_match;
   logic          rpt_clr, rpt_ld, rpt_inc, rpt_match;
   logic [CW-1:0] cnt_term, cnt_val;
   logic [RW-1:0] rpt_val;

   assign onehot    = ($countones(keys_pressed) == 1);
   assign qual      = onehot && (keys_pressed == cand);
   assign locked_hi = |(keys_pressed & cand);

   // Counter controls: cnt tracks consecutive press/release samples, rpt
   // counts HELD cycles and wraps from DELAY+RATE back to DELAY.
   always_comb begin
      cnt_clr  = 1'b0;
      cnt_ld   = 1'b0;
      cnt_inc  = 1'b0;
      rpt_clr  = 1'b0;
      rpt_ld   = 1'b0;
      rpt_inc  = 1'b0;
      rpt_fire = 1'b0;
      cnt_term = PRESS_T;
      case (state)
         IDLE: begin
            rpt_clr = 1'b1;
            if (onehot) cnt_ld  = 1'b1;
            else        cnt_clr = 1'b1;
         end
         PRESS_WAIT: begin
            rpt_clr = 1'b1;
            if (qual && !cnt_match) cnt_inc = 1'b1;
            else                    cnt_clr = 1'b1;
         end
         HELD: begin
            if (!locked_hi) cnt_ld = 1'b1;
            else if (REPEAT_EN != 0) begin
               rpt_fire = (rpt_val == RPT_FST) || rpt_match;
               if (rpt_match) rpt_ld  = 1'b1;
               else           rpt_inc = 1'b1;
            end
         end
         REL_WAIT: begin
            cnt_term = REL_T;
            if (!locked_hi && !cnt_match) cnt_inc = 1'b1;
            else                          cnt_clr = 1'b1;
            if (locked_hi) rpt_clr = 1'b1;
         end
         default: cnt_clr = 1'b1;
      endcase
   end

   debounce_counter #(.W(CW)) u_cnt (
      .clk(clk), .reset(reset), .clear(cnt_clr), .load(cnt_ld), .inc(cnt_inc),
      .load_val(CW'(1)), .term(cnt_term), .count(cnt_val), .match(cnt_match)
   );

   debounce_counter #(.W(RW)) u_rpt (
      .clk(clk), .reset(reset), .clear(rpt_clr), .load(rpt_ld), .inc(rpt_inc),
      .load_val(RPT_LD), .term(RPT_WRAP), .count(rpt_val), .match(rpt_match)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= IDLE;
         cand              <= '0;
         key_pressed_value <= '0;
         key_index         <= '0;
         new_key           <= 1'b0;
         key_released      <= 1'b0;
         key_held          <= 1'b0;
      end else begin
         new_key      <= 1'b0;
         key_released <= 1'b0;
         case (state)
            IDLE: if (onehot) begin
               cand <= keys_pressed;
               if (PRESS_CYCLES == 1) begin
                  state             <= HELD;
                  key_pressed_value <= keys_pressed;
                  key_index         <= IW'(onehot_to_index(MAX_KEYS'(keys_pressed)));
                  new_key           <= 1'b1;
                  key_held          <= 1'b1;
               end else
                  state <= PRESS_WAIT;
            end
            PRESS_WAIT: begin
               if (!qual) state <= IDLE;
               else if (cnt_match) begin
                  state             <= HELD;
                  key_pressed_value <= cand;
                  key_index         <= IW'(onehot_to_index(MAX_KEYS'(cand)));
                  new_key           <= 1'b1;
                  key_held          <= 1'b1;
               end
            end
            HELD: begin
               if (!locked_hi) begin
                  if (RELEASE_CYCLES == 1) begin
                     state        <= IDLE;
                     key_released <= 1'b1;
                     key_held     <= 1'b0;
                  end else
                     state <= REL_WAIT;
               end else if (rpt_fire)
                  new_key <= 1'b1;
            end
            REL_WAIT: begin
               if (locked_hi) state <= HELD;
               else if (cnt_match) begin
                  state        <= IDLE;
                  key_released <= 1'b1;
                  key_held     <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_debouncer.sv
// Directed + random bench for keypad_debouncer: two instances (repeat off/on)
// checked every cycle against a run-length reference model.
module tb_keypad_debouncer;

   localparam int NK = 16, PC = 4, RC = 4, RD = 8, RR = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [NK-1:0] keys;
   logic [NK-1:0] val0, val1;
   logic [3:0]    idx0, idx1;
   logic          nk0, nk1, rel0, rel1, hld0, hld1;

   int n_cmp = 0, n_err = 0, pulses = 0;

   always #5 clk = ~clk;

   keypad_debouncer #(.NUM_KEYS(NK), .PRESS_CYCLES(PC), .RELEASE_CYCLES(RC),
      .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) u0 (
      .clk(clk), .reset(reset), .keys_pressed(keys), .key_pressed_value(val0),
      .key_index(idx0), .new_key(nk0), .key_released(rel0), .key_held(hld0));

   keypad_debouncer #(.NUM_KEYS(NK), .PRESS_CYCLES(PC), .RELEASE_CYCLES(RC),
      .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) u1 (
      .clk(clk), .reset(reset), .keys_pressed(keys), .key_pressed_value(val1),
      .key_index(idx1), .new_key(nk1), .key_released(rel1), .key_held(hld1));

   // Reference model: counts runs of identical one-hot samples, runs of low
   // samples on the locked key, and cycles the key has been continuously held.
   bit            locked [2];
   int            run [2], low [2], age [2], m_idx [2];
   logic [NK-1:0] cand [2], m_val [2];
   bit            m_new [2], m_rel [2], m_held [2];

   function automatic int ones(input logic [NK-1:0] v);
      int n = 0;
      for (int i = 0; i < NK; i++) n += int'(v[i]);
      return n;
   endfunction

   task automatic model_step(input int u);
      bit oh;
      oh = (ones(keys) == 1);
      if (reset) begin
         locked[u] = 0; run[u] = 0; low[u] = 0; age[u] = 0;
         cand[u] = '0; m_val[u] = '0; m_idx[u] = 0;
         m_new[u] = 0; m_rel[u] = 0; m_held[u] = 0;
         return;
      end
      m_new[u] = 0; m_rel[u] = 0;
      if (!locked[u]) begin
         if (run[u] == 0) begin
            if (oh) begin cand[u] = keys; run[u] = 1; end
         end else if (oh && keys == cand[u]) run[u]++;
         else run[u] = 0;
         if (run[u] == PC) begin
            locked[u] = 1; run[u] = 0; low[u] = 0; age[u] = 0;
            m_val[u] = cand[u]; m_new[u] = 1; m_held[u] = 1;
            for (int i = 0; i < NK; i++) if (cand[u][i]) m_idx[u] = i;
         end
      end else if ((keys & cand[u]) != '0) begin
         if (low[u] > 0) begin low[u] = 0; age[u] = 0; end
         else begin
            age[u]++;
            if (u == 1 && (age[u] == RD || (age[u] > RD && (age[u] - RD) % RR == 0)))
               m_new[u] = 1;
         end
      end else begin
         low[u]++;
         if (low[u] == RC) begin
            locked[u] = 0; low[u] = 0; run[u] = 0;
            m_rel[u] = 1; m_held[u] = 0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc(input logic [NK-1:0] k, input bit r);
      keys = k; reset = r;
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      if (nk1) pulses++;
      chk("val0", 32'(val0), 32'(m_val[0]));
      chk("idx0", 32'(idx0), 32'(m_idx[0]));
      chk("new0", 32'(nk0),  32'(m_new[0]));
      chk("rel0", 32'(rel0), 32'(m_rel[0]));
      chk("hld0", 32'(hld0), 32'(m_held[0]));
      chk("val1", 32'(val1), 32'(m_val[1]));
      chk("idx1", 32'(idx1), 32'(m_idx[1]));
      chk("new1", 32'(nk1),  32'(m_new[1]));
      chk("rel1", 32'(rel1), 32'(m_rel[1]));
      chk("hld1", 32'(hld1), 32'(m_held[1]));
      chk("excl", 32'(nk0 & rel0 | nk1 & rel1), 32'(0));
   endtask

   task automatic seq(input logic [NK-1:0] k, input int n);
      for (int i = 0; i < n; i++) cyc(k, 1'b0);
   endtask

   initial begin
      keys = '0; reset = 1'b1;
      cyc('0, 1'b1);
      cyc('0, 1'b1);
      chk("rst_val", 32'(val0), 32'(0));

      // clean press, then release
      seq(16'h0010, 3);
      chk("early_new", 32'(nk0), 32'(0));
      seq(16'h0010, 1);
      chk("accept_new", 32'(nk0), 32'(1));
      seq(16'h0010, 2);
      chk("t1_val", 32'(val0), 32'h10);
      chk("t1_idx", 32'(idx0), 32'd4);
      chk("t1_held", 32'(hld0), 32'd1);
      seq('0, 5);

      // bounce during press
      seq(16'h0010, 3); seq('0, 1); seq(16'h0010, 4); seq('0, 5);

      // multi-key, then chording while locked
      seq(16'h0011, 10); seq(16'h0001, 6); seq(16'h0101, 4);
      chk("t3_val", 32'(val0), 32'h1);

      // release with bounce
      seq('0, 2); seq(16'h0001, 1); seq('0, 4);
      chk("t4_val", 32'(val0), 32'h1);
      seq('0, 2);

      // typematic repeat on instance 1
      pulses = 0;
      seq(16'h0200, 30);
      chk("rpt_count", 32'(pulses), 32'd6);
      seq('0, 6);

      // reset in PRESS_WAIT and in HELD
      seq(16'h0008, 2); cyc(16'h0008, 1'b1);
      seq(16'h0008, 3);
      chk("fresh_early", 32'(nk0), 32'(0));
      seq(16'h0008, 4); cyc(16'h0008, 1'b1);
      chk("rst_held", 32'(hld0), 32'(0));
      seq('0, 6);

      // random segments
      for (int s = 0; s < 80; s++) begin
         int len, kind;
         logic [NK-1:0] k;
         len  = $urandom_range(1, 12);
         kind = $urandom_range(0, 19);
         k    = '0;
         if (kind >= 4 && kind <= 15) k[$urandom_range(0, NK-1)] = 1'b1;
         else if (kind >= 16) begin
            k[$urandom_range(0, NK-1)] = 1'b1;
            k[$urandom_range(0, NK-1)] = 1'b1;
         end
         if (kind == 3) cyc(k, 1'b1);
         seq(k, len);
      end
      seq('0, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/keypad_debouncer.md
Name: keypad_debouncer

Overview:
- Parametrised successor to the keypad jitter controller.
- Debounces an N-key, already-synchronised, active-high key vector and locks onto a single key.
- Emits a one-cycle new_key pulse on each accepted press and a key_released pulse on release, with optional typematic auto-repeat.
- Sits between the keypad scanner/synchroniser and the display/digit-history logic.

Parameters:
- NUM_KEYS, 16: width of the key vector; must be ≥ 2.
- PRESS_CYCLES, 4: consecutive qualifying samples required to accept a press; must be ≥ 1.
- RELEASE_CYCLES, 4: consecutive samples with the locked key low required to accept a release; must be ≥ 1.
- REPEAT_EN, 0: 1 enables auto-repeat pulses on new_key while the key is held.
- REPEAT_DELAY, 8: HELD cycles before the first repeat pulse; must be ≥ 1.
- REPEAT_RATE, 4: HELD cycles between subsequent repeat pulses; must be ≥ 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- keys_pressed  input  NUM_KEYS  raw key states, already synchronised to clk
- key_pressed_value  output  NUM_KEYS  one-hot last accepted key; 0 until the first accept
- key_index  output  $clog2(NUM_KEYS)  binary index of key_pressed_value
- new_key  output  1  one-cycle pulse per accepted press or repeat
- key_released  output  1  one-cycle pulse when the locked key's release is accepted
- key_held  output  1  high in HELD and REL_WAIT

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high, dominates everything): state = IDLE, counters = 0, all outputs = 0. Reset mid-press or mid-hold aborts silently; no key_released pulse.
- Qualifying sample: keys_pressed is exactly one-hot AND equals the candidate. In IDLE, any exactly-one-hot sample qualifies and becomes the candidate.
- IDLE:
  - Zero or multiple bits set: stay in IDLE; cnt = 0.
  - One-hot sample: capture candidate, cnt = 1.
    - If PRESS_CYCLES == 1, go directly to HELD and accept.
    - Otherwise go to PRESS_WAIT.
- PRESS_WAIT:
  - Qualifying sample: cnt++.
    - When the sample is the PRESS_CYCLES-th consecutive qualifier, go to HELD.
  - Any non-qualifying sample (other key, extra key, or none): go to IDLE, cnt = 0. No output change.
- Accept (entry to HELD):
  - key_pressed_value = candidate; key_index updated.
  - new_key = 1 for exactly the cycle after the accepting edge.
  - rpt = 0.
  - Latency: new_key is high in the cycle following the edge that sampled the PRESS_CYCLES-th consecutive qualifier.
- HELD:
  - Only the locked bit is observed; other keys are ignored, so chording is not reported.
  - Locked bit low: go to REL_WAIT, cnt = 1.
    - If RELEASE_CYCLES == 1, release immediately instead.
  - REPEAT_EN = 1: rpt increments every HELD cycle.
    - new_key pulses when rpt reaches REPEAT_DELAY, then every REPEAT_RATE cycles after that.
    - rpt saturates/wraps internally so no overflow occurs.
    - key_pressed_value is unchanged by repeats.
- REL_WAIT:
  - Locked bit low: cnt++. At RELEASE_CYCLES consecutive low samples, go to IDLE and pulse key_released.
  - key_pressed_value stays at the last key (not cleared); key_held drops to 0.
  - Locked bit high again (bounce): return to HELD with rpt = 0; no new_key pulse.
- Simultaneous events:
  - A new one-hot key seen on the same edge that release completes is not captured. IDLE evaluates it on the next edge.
  - new_key and key_released are never high in the same cycle.
- Width rules:
  - cnt width = $clog2(max(PRESS_CYCLES, RELEASE_CYCLES) + 1).
  - rpt width = $clog2(REPEAT_DELAY + REPEAT_RATE + 1).
  - One-hot check is popcount == 1, evaluated combinationally.

Decomposition:
- Package keypad_pkg: state enum (IDLE, PRESS_WAIT, HELD, REL_WAIT) and function onehot_to_index.
- Sub-module debounce_counter: loadable, clearable up-counter with a terminal-match output. It is instantiated twice, once as cnt and once as rpt.
- The FSM and output registers live in the top module.

Test Plan (PRESS_CYCLES=4, RELEASE_CYCLES=4 unless noted):
1. Clean press: keys = 0x0010 held for 6 cycles → new_key high exactly 1 cycle, 4 cycles after the first sample; key_pressed_value = 0x0010, key_index = 4, key_held = 1.
2. Bounce: 0x0010 for 3 cycles, 0x0000 for 1, then 0x0010 for 4 → exactly one new_key, after the second run; no pulse after the first run.
3. Multi-key: 0x0011 for 10 cycles → no new_key, state IDLE. Then 0x0001 held → accept with key_index = 0. While 0x0001 is held, add 0x0100 → no new pulse, value stays 0x0001.
4. Release: after accept, keys = 0 for 2 cycles, back to 0x0001 for 1, then 0 for 4 → single key_released pulse after the final 4th low sample; key_pressed_value stays 0x0001.
5. Repeat (REPEAT_EN=1, REPEAT_DELAY=8, REPEAT_RATE=4): hold 0x0200 for 30 cycles → new_key pulses at accept, +8 cycles, then every 4 cycles; 6 pulses total with correct spacing.
6. Reset: assert reset in PRESS_WAIT and again in HELD → all outputs 0 the following cycle, no key_released pulse. After deassert, a fresh press needs the full 4 samples.
